// File: rtl/intr_ctrl.sv
// Interrupt controller: rising-edge capture into pending, mask, fixed priority (src 0 highest),
// irq/irq_ack/EOI handshake with the CPU. Define INTC_AUTO_EOI_EN to retire requests on ack.
module intr_ctrl #(
   parameter int DATAWID = 16,
   parameter int NUM_SRC = 8,
   parameter int VECWID  = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cs,
   input  logic               wr,
   input  logic               rd,
   input  logic [1:0]         addr,
   input  logic [DATAWID-1:0] datain,
   output logic [DATAWID-1:0] dataout,
   input  logic [NUM_SRC-1:0] src,
   output logic               irq,
   input  logic               irq_ack,
   output logic [VECWID-1:0]  irq_vec
);

   typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

   state_t               state_q, state_d;
   logic [NUM_SRC-1:0]   src_dly_q, src_dly_d;
   logic [NUM_SRC-1:0]   pending_q, pending_d;
   logic [NUM_SRC-1:0]   mask_q, mask_d;
   logic                 insvc_q, insvc_d;
   logic                 irq_q, irq_d;
   logic [VECWID-1:0]    irq_vec_q, irq_vec_d;
   logic [DATAWID-1:0]   dataout_q, dataout_d;

   logic [NUM_SRC-1:0]   src_edge;
   logic [NUM_SRC-1:0]   active_req;
   logic [NUM_SRC-1:0]   ack_clr;
   logic [VECWID-1:0]    first_idx;
   logic                 any_req;
   logic                 ack_in_req;
   logic                 mask_wr;
   logic                 pend_wr;
   logic                 unused_datain;

   assign unused_datain = ^datain;
   assign mask_wr    = cs & wr & (addr == 2'd0);
   assign pend_wr    = cs & wr & (addr == 2'd1);
   assign src_edge   = src & ~src_dly_q;
   assign active_req = pending_q & ~mask_q;
   assign any_req    = |active_req;
   assign ack_in_req = (state_q == REQ) & irq_ack;

`ifndef INTC_AUTO_EOI_EN
   logic eoi_wr;
   assign eoi_wr = cs & wr & (addr == 2'd3);
`endif

   // Scan downwards so the lowest-numbered active source wins
   always_comb begin
      first_idx = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (active_req[i]) first_idx = VECWID'(i);
      end
   end

   always_ff @(posedge clk) begin
      src_dly_q <= src_dly_d;
      if (rst) begin
         state_q   <= IDLE;
         pending_q <= '0;
         mask_q    <= '1;
         insvc_q   <= 1'b0;
         irq_q     <= 1'b0;
         irq_vec_q <= '0;
         dataout_q <= '0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         mask_q    <= mask_d;
         insvc_q   <= insvc_d;
         irq_q     <= irq_d;
         irq_vec_q <= irq_vec_d;
         dataout_q <= dataout_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (any_req) state_d = REQ;
`ifdef INTC_AUTO_EOI_EN
         REQ:     if (irq_ack) state_d = IDLE;
         SERVICE: state_d = IDLE;
`else
         REQ:     if (irq_ack) state_d = SERVICE;
         SERVICE: if (eoi_wr) state_d = IDLE;
`endif
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      irq_d     = irq_q;
      irq_vec_d = irq_vec_q;
      insvc_d   = insvc_q;
      case (state_q)
         IDLE: begin
            if (any_req) begin
               irq_d     = 1'b1;
               irq_vec_d = first_idx;
            end
         end
         REQ: begin
            if (irq_ack) begin
               irq_d = 1'b0;
`ifndef INTC_AUTO_EOI_EN
               insvc_d = 1'b1;
`endif
            end
         end
         SERVICE: begin
`ifndef INTC_AUTO_EOI_EN
            if (eoi_wr) insvc_d = 1'b0;
`endif
         end
         default: begin
            irq_d   = 1'b0;
            insvc_d = 1'b0;
         end
      endcase
   end

   generate
      for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_ack_dec
         assign ack_clr[gi] = ack_in_req & (irq_vec_q == VECWID'(gi));
      end
   endgenerate

   // New edges are applied last so they win over W1C and ack clears on the same bit
   always_comb begin
      src_dly_d = src;
      mask_d    = mask_q;
      pending_d = pending_q & ~ack_clr;
      if (mask_wr) mask_d = datain[NUM_SRC-1:0];
      if (pend_wr) pending_d = pending_d & ~datain[NUM_SRC-1:0];
      pending_d = pending_d | src_edge;
   end

   always_comb begin
      dataout_d = dataout_q;
      if (cs & rd) begin
         case (addr)
            2'd0:    dataout_d = DATAWID'(mask_q);
            2'd1:    dataout_d = DATAWID'(pending_q);
            2'd2:    dataout_d = DATAWID'({insvc_q, irq_q, irq_vec_q});
            default: dataout_d = '0;
         endcase
      end
   end

   assign dataout = dataout_q;
   assign irq     = irq_q;
   assign irq_vec = irq_vec_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl; define INTC_AUTO_EOI_EN for both files to exercise auto-EOI.
module tb_intr_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        cs, wr, rd;
   logic [1:0]  addr;
   logic [15:0] datain;
   logic [15:0] dataout;
   logic [7:0]  src;
   logic        irq;
   logic        irq_ack;
   logic [2:0]  irq_vec;
   logic [15:0] rdata;

   int n_cmp = 0;
   int n_bad = 0;

   intr_ctrl #(.DATAWID(16), .NUM_SRC(8), .VECWID(3)) dut (
      .clk     (clk),
      .rst     (rst),
      .cs      (cs),
      .wr      (wr),
      .rd      (rd),
      .addr    (addr),
      .datain  (datain),
      .dataout (dataout),
      .src     (src),
      .irq     (irq),
      .irq_ack (irq_ack),
      .irq_vec (irq_vec)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
      cs = 1'b1; wr = 1'b1; addr = a; datain = d;
      tick();
      cs = 1'b0; wr = 1'b0; datain = '0;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [15:0] d);
      cs = 1'b1; rd = 1'b1; addr = a;
      tick();
      cs = 1'b0; rd = 1'b0;
      d = dataout;
   endtask

   task automatic ack_pulse();
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
   endtask

   initial begin
      rst = 1'b1; cs = 1'b0; wr = 1'b0; rd = 1'b0; addr = '0; datain = '0;
      src = 8'h01; irq_ack = 1'b0;
      repeat (3) tick();
      check_val("rst_dataout", 32'(dataout), 32'h0);
      check_val("rst_irq", 32'(irq), 32'h0);
      check_val("rst_vec", 32'(irq_vec), 32'h0);
      rst = 1'b0;

      // Level high across reset release is not an edge
      bus_read(2'd1, rdata);
      check_val("no_edge_pending", 32'(rdata), 32'h0);
      bus_read(2'd0, rdata);
      check_val("rst_mask", 32'(rdata), 32'hFF);
      check_val("no_edge_irq", 32'(irq), 32'h0);

      // Single source, upper write bits dropped
      src = 8'h00;
      tick();
      bus_write(2'd0, 16'hFFFE);
      bus_read(2'd0, rdata);
      check_val("mask_fe", 32'(rdata), 32'h00FE);
      src = 8'h01;
      tick();
      check_val("s0_irq_lat1", 32'(irq), 32'h0);
      tick();
      check_val("s0_irq", 32'(irq), 32'h1);
      check_val("s0_vec", 32'(irq_vec), 32'h0);
      ack_pulse();
      check_val("s0_ack_irq", 32'(irq), 32'h0);
      src = 8'h00;
      bus_read(2'd2, rdata);
      check_val("s0_status", 32'(rdata), 32'h10);
      ack_pulse();
      bus_read(2'd2, rdata);
      check_val("ack_in_svc", 32'(rdata), 32'h10);
      bus_write(2'd3, 16'h0);
      bus_read(2'd2, rdata);
      check_val("s0_eoi_status", 32'(rdata), 32'h00);

      // Two simultaneous edges: priority then post-EOI follow-up
      bus_write(2'd0, 16'h0000);
      src = 8'h24;
      tick();
      tick();
      check_val("dual_irq", 32'(irq), 32'h1);
      check_val("dual_vec2", 32'(irq_vec), 32'h2);
      ack_pulse();
      bus_read(2'd1, rdata);
      check_val("dual_pend", 32'(rdata), 32'h20);
      bus_read(2'd2, rdata);
      check_val("dual_status", 32'(rdata), 32'h12);
      src = 8'h00;
      bus_write(2'd3, 16'h0);
      check_val("eoi_gap_irq", 32'(irq), 32'h0);
      tick();
      check_val("dual_irq5", 32'(irq), 32'h1);
      check_val("dual_vec5", 32'(irq_vec), 32'h5);
      bus_read(2'd2, rdata);
      check_val("dual_status5", 32'(rdata), 32'h0D);
      ack_pulse();
      bus_write(2'd3, 16'h0);

      // Masked source, unmask, W1C racing a new edge
      bus_write(2'd0, 16'h0008);
      src = 8'h08;
      tick();
      tick();
      check_val("masked_irq", 32'(irq), 32'h0);
      bus_read(2'd1, rdata);
      check_val("masked_pend", 32'(rdata), 32'h08);
      bus_write(2'd0, 16'h0000);
      tick();
      check_val("unmask_irq", 32'(irq), 32'h1);
      check_val("unmask_vec", 32'(irq_vec), 32'h3);
      ack_pulse();
      check_val("s3_ack_irq", 32'(irq), 32'h0);
      src = 8'h00;
      tick();
      src = 8'h08;
      bus_write(2'd1, 16'h0008);
      bus_read(2'd1, rdata);
      check_val("w1c_vs_edge", 32'(rdata), 32'h08);

      // Reset while in SERVICE
      rst = 1'b1;
      tick();
      check_val("midrst_irq", 32'(irq), 32'h0);
      check_val("midrst_dout", 32'(dataout), 32'h0);
      rst = 1'b0;
      bus_read(2'd2, rdata);
      check_val("midrst_status", 32'(rdata), 32'h0);
      bus_read(2'd1, rdata);
      check_val("midrst_pend", 32'(rdata), 32'h0);
      bus_read(2'd0, rdata);
      check_val("midrst_mask", 32'(rdata), 32'hFF);

      // Back-to-back requests: behaviour depends on EOI mode
      src = 8'h00;
      tick();
      bus_write(2'd0, 16'h0000);
      src = 8'h06;
      tick();
      tick();
      check_val("b2b_irq1", 32'(irq), 32'h1);
      check_val("b2b_vec1", 32'(irq_vec), 32'h1);
      ack_pulse();
      check_val("b2b_ack_irq", 32'(irq), 32'h0);
`ifdef INTC_AUTO_EOI_EN
      tick();
      check_val("auto_irq2", 32'(irq), 32'h1);
      check_val("auto_vec2", 32'(irq_vec), 32'h2);
      bus_read(2'd2, rdata);
      check_val("auto_status", 32'(rdata), 32'h0A);
`else
      tick();
      check_val("noeoi_irq", 32'(irq), 32'h0);
      bus_read(2'd2, rdata);
      check_val("noeoi_status", 32'(rdata), 32'h11);
      bus_write(2'd3, 16'h0);
      tick();
      check_val("eoi_irq2", 32'(irq), 32'h1);
      check_val("eoi_vec2", 32'(irq_vec), 32'h2);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
